// File: rtl/pipereg_skid.sv
// Two-entry skid pipeline register with flush, NOP insertion
// and a saturating downstream bubble counter.
module pipereg_skid #(
  parameter int unsigned   DW       = 32,
  parameter int unsigned   CNT_W    = 16,
  parameter logic [DW-1:0] NOP_DATA = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  state_t           state_n;
  logic [DW-1:0]    m_q;
  logic [DW-1:0]    m_n;
  logic [DW-1:0]    s_q;
  logic [DW-1:0]    s_n;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             pop;
  logic             bubble;

  // Handshake outputs come from the state register only
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? m_q : NOP_DATA;
  assign occupancy = state_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign bubble = out_ready & ~out_valid & ~flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= EMPTY;
      m_q     <= NOP_DATA;
      s_q     <= NOP_DATA;
    end else begin
      state_q <= state_n;
      m_q     <= m_n;
      s_q     <= s_n;
    end
  end

  always_comb begin
    state_n = state_q;
    m_n     = m_q;
    s_n     = s_q;
    if (flush) begin
      state_n = EMPTY;
      m_n     = NOP_DATA;
      s_n     = NOP_DATA;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_n = ONE;
            m_n     = in_data;
          end
        end
        ONE: begin
          unique case ({accept, pop})
            2'b11: m_n = in_data;
            2'b10: begin
              state_n = FULL;
              s_n     = in_data;
            end
            2'b01: begin
              state_n = EMPTY;
              m_n     = NOP_DATA;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            state_n = ONE;
            m_n     = s_q;
            s_n     = NOP_DATA;
          end
        end
        default: begin
          state_n = EMPTY;
          m_n     = NOP_DATA;
          s_n     = NOP_DATA;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
    end else if (bubble && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipereg_skid.sv
// Scoreboard bench for pipereg_skid: queue reference model,
// directed scenarios and randomized traffic.
module tb_pipereg_skid;

  localparam int DW = 32;
  localparam int CW = 2;
  localparam logic [DW-1:0] NOP = 32'h0BAD_F00D;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    occupancy;
  logic          clr_cnt;
  logic [CW-1:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q[$];
  int occ_exp = 0;
  int bub_exp = 0;

  pipereg_skid #(
    .DW(DW),
    .CNT_W(CW),
    .NOP_DATA(NOP)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .occupancy(occupancy),
    .clr_cnt(clr_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: samples just before each rising edge
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge CLK);
      #4;
      if (nRST) begin
        chk("occupancy", 32'(occupancy), 32'(occ_exp));
        chk("in_ready", 32'(in_ready), 32'(occ_exp < 2));
        chk("out_valid", 32'(out_valid), 32'(occ_exp > 0));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(bub_exp));
        if (!out_valid) begin
          chk("nop_data", out_data, NOP);
        end else if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pop", out_data, NOP);
          end else begin
            e = exp_q.pop_front();
            chk("pop_data", out_data, e);
          end
        end
      end
    end
  end

  // One clock of stimulus plus reference-model update
  task automatic cycle(input logic v, input logic [DW-1:0] d,
                       input logic r, input logic f,
                       input logic c);
    bit acc;
    bit pp;
    int nocc;
    int nb;
    @(negedge CLK);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    clr_cnt   = c;
    #2;
    acc = v && (occ_exp < 2) && !f;
    pp  = (occ_exp > 0) && r;
    if (f) nocc = 0;
    else nocc = occ_exp + int'(acc) - int'(pp);
    if (acc) exp_q.push_back(d);
    nb = bub_exp;
    if (c) nb = 0;
    else if (r && occ_exp == 0 && !f && bub_exp < 3) nb = bub_exp + 1;
    @(posedge CLK);
    #1;
    occ_exp = nocc;
    bub_exp = nb;
    if (f) exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_data"}, out_data, NOP);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic rst_pulse();
    #1;
    nRST = 1'b0;
    exp_q.delete();
    occ_exp = 0;
    bub_exp = 0;
    #1;
    chk_reset_outputs("async_rst");
    chk("async_rst_bubble", 32'(bubble_cnt), 32'd0);
    nRST = 1'b1;
  endtask

  initial begin
    nRST      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    #2;
    chk_reset_outputs("reset");
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs("reset_hold");
    nRST = 1'b1;

    // single entry, one-cycle latency
    cycle(1, 32'hA5A5_A5A5, 0, 0, 0);
    chk("lat_data", out_data, 32'hA5A5_A5A5);
    chk("lat_valid", 32'(out_valid), 32'd1);
    cycle(0, 32'h0, 1, 0, 0);

    // fill, hold-off, drain in order
    cycle(1, 32'h1, 0, 0, 0);
    cycle(1, 32'h2, 0, 0, 0);
    chk("full_ready", 32'(in_ready), 32'd0);
    cycle(1, 32'h3, 0, 0, 0);
    cycle(1, 32'h3, 1, 0, 0);
    cycle(1, 32'h3, 1, 0, 0);
    cycle(0, 32'h0, 1, 0, 0);
    cycle(0, 32'h0, 0, 0, 0);

    // full-throughput stream
    for (int i = 0; i < 100; i++) cycle(1, 32'(i), 1, 0, 0);
    cycle(0, 32'h0, 1, 0, 0);

    // flush while full discards the concurrent accept
    cycle(1, 32'h7, 0, 0, 0);
    cycle(1, 32'h8, 0, 0, 0);
    cycle(1, 32'h9, 0, 1, 0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_data", out_data, NOP);
    cycle(0, 32'h0, 0, 0, 0);

    // bubble counter saturation and clear
    cycle(0, 32'h0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 32'h0, 1, 0, 0);
    chk("bubble_sat", 32'(bubble_cnt), 32'd3);
    cycle(0, 32'h0, 1, 0, 1);
    chk("bubble_clr", 32'(bubble_cnt), 32'd0);

    // async reset while full
    cycle(1, 32'h11, 0, 0, 0);
    cycle(1, 32'h22, 0, 0, 0);
    rst_pulse();
    cycle(1, 32'h33, 0, 0, 0);
    chk("post_rst_data", out_data, 32'h33);
    cycle(0, 32'h0, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 9) < 7,
            $urandom,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 3);
      if ($urandom_range(0, 499) == 0) rst_pulse();
    end

    repeat (3) cycle(0, 32'h0, 1, 0, 0);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipereg_skid.md
PIPEREG_SKID -- requirements
Module: pipereg_skid

Interface
REQ-001 Parameter DW, default 32, data payload width in bits (DW >= 1).
REQ-002 Parameter CNT_W, default 16, bubble counter width in bits (CNT_W >= 2).
REQ-003 Parameter NOP_DATA, default all-zeros DW-bit word, value driven on out_data when the stage is empty or flushed.
REQ-004 CLK  input  1  rising-edge clock, single clock domain.
REQ-005 nRST  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous flush: drop all held entries (NOP insertion).
REQ-007 in_valid  input  1  upstream presents a valid entry.
REQ-008 in_data  input  DW  upstream payload; ignored when in_valid=0.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 out_valid  output  1  stage presents a valid entry downstream.
REQ-011 out_data  output  DW  head payload.
REQ-012 out_ready  input  1  downstream consumes the head this cycle.
REQ-013 occupancy  output  2  number of held entries, 0..2.
REQ-014 clr_cnt  input  1  synchronous clear of bubble_cnt.
REQ-015 bubble_cnt  output  CNT_W  saturating count of downstream bubble cycles.

Function
REQ-016 Storage: main register M (head) and skid register S; states EMPTY (occ 0), ONE (occ 1, M valid), FULL (occ 2, M head, S second).
REQ-017 Accept = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on the same rising edge.
REQ-018 in_ready = (state != FULL), decoded from state register only; no combinational path from out_ready or in_valid.
REQ-019 out_valid = (state != EMPTY); out_data = M when out_valid=1, else NOP_DATA; occupancy = state encoding 0/1/2.
REQ-020 EMPTY: accept -> ONE, M <= in_data; otherwise stay.
REQ-021 ONE: accept & pop -> ONE, M <= in_data; accept only -> FULL, S <= in_data; pop only -> EMPTY, M <= NOP_DATA; neither -> stay.
REQ-022 FULL: pop -> ONE, M <= S, S <= NOP_DATA; no pop -> stay, M and S hold (no accept possible since in_ready=0).
REQ-023 Order preserved: entries leave in exactly the order accepted; no duplication, no loss except by flush.
REQ-024 Latency: entry accepted at edge k into EMPTY is on out_data with out_valid=1 immediately after edge k (one cycle).
REQ-025 Full throughput: in ONE with in_valid=1 and out_ready=1 every cycle, one entry accepted and one popped per cycle indefinitely.
REQ-026 flush=1 has highest priority: next state EMPTY, M and S <= NOP_DATA, any accept that cycle discarded, any pop that cycle still completes downstream (head seen by consumer).
REQ-027 Held data unchanged while no accept/pop/flush occurs, regardless of in_data toggling.
REQ-028 bubble_cnt increments by 1 on each edge where out_ready=1, out_valid=0, flush=0; saturates at 2^CNT_W-1 (no wrap).
REQ-029 clr_cnt=1 sets bubble_cnt to 0 on that edge, priority over increment.

Reset
REQ-030 nRST=0 immediately (asynchronously) forces state EMPTY, M and S to NOP_DATA, bubble_cnt to 0.
REQ-031 During and after reset: out_valid=0, out_data=NOP_DATA, occupancy=0, in_ready=1.
REQ-032 Reset asserted mid-operation discards all held entries; first accept after deassertion behaves per REQ-020.

Verification
REQ-033 Reset then in_valid=1, in_data=0xA5A5A5A5, out_ready=0 for one edge -> out_valid=1, out_data=0xA5A5A5A5, occupancy=1, in_ready=1.
REQ-034 out_ready=0, push 0x1, 0x2 -> occupancy=2, in_ready=0; third push 0x3 held off; raise out_ready -> outputs 0x1, 0x2, 0x3 in order on consecutive cycles.
REQ-035 Stream 0..99 with in_valid=1, out_ready=1 every cycle -> 100 pops on 100 consecutive cycles after first, values 0..99, occupancy stays 1.
REQ-036 FULL (0x7, 0x8) with flush=1 and in_valid=1 (0x9) same edge -> occupancy=0, out_data=NOP_DATA, 0x9 never appears.
REQ-037 CNT_W=2, out_ready=1, empty for 5 edges -> bubble_cnt 1,2,3,3,3; clr_cnt=1 -> 0.
REQ-038 nRST pulsed low between edges while FULL -> out_valid=0, occupancy=0, in_ready=1 without a clock edge.
